// File: rtl/cla_seq_if.sv
// Start/done handshake and operand/result bundle for the sequential CLA adder.
// The master drives operands and start; the slave returns the result and status.
interface cla_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, cin, sub,
    input  S, cout, ovf, busy, done
  );

  modport slave (
    input  start, A, B, cin, sub,
    output S, cout, ovf, busy, done
  );
endinterface

// File: rtl/cla_seq_adder.sv
// Multi-cycle adder: one CHUNK-bit carry-lookahead slice per clock, carry kept in c_q.
// Optional subtract support is compiled in with `define CLA_SEQ_SUB_EN.
module cla_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  cla_seq_if.slave   bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef CLA_SEQ_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic             accept;
  logic             last;
  logic [CHUNK-1:0] sl_a;
  logic [CHUNK-1:0] sl_b;
  logic [CHUNK-1:0] sl_sum;
  logic [CHUNK:0]   sl_c;

  // Fully expanded lookahead: each carry is a sum of generate terms
  // propagated through the intervening p bits, plus the incoming carry.
  function automatic logic [CHUNK:0] cla_carry(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             c0
  );
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] g;
    logic [CHUNK:0]   c;
    logic             t;
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < CHUNK; i++) begin
      t = c0;
      for (int k = 0; k <= i; k++) t = t & p[k];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int k = j + 1; k <= i; k++) t = t & p[k];
        c[i+1] = c[i+1] | t;
      end
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CLA_SEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  always_comb begin
    accept  = bus.start && (state_q == IDLE || state_q == DONE);
    last    = (idx_q == LAST);
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? RUN : IDLE;
      RUN:     state_d = last ? DONE : RUN;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sl_a = a_q[idx_q*CHUNK +: CHUNK];
    sl_b = b_q[idx_q*CHUNK +: CHUNK];
`ifdef CLA_SEQ_SUB_EN
    if (sub_q) sl_b = ~sl_b;
`endif
    sl_c   = cla_carry(sl_a, sl_b, c_q);
    sl_sum = sl_a ^ sl_b ^ sl_c[CHUNK-1:0];
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    s_d    = s_q;
    idx_d  = idx_q;
    c_d    = c_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    busy_d = busy_q;
    done_d = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    sub_d  = sub_q;
`endif
    if (accept) begin
      a_d    = bus.A;
      b_d    = bus.B;
      s_d    = '0;
      idx_d  = '0;
      c_d    = bus.cin;
      cout_d = 1'b0;
      ovf_d  = 1'b0;
      busy_d = 1'b1;
`ifdef CLA_SEQ_SUB_EN
      sub_d  = bus.sub;
      if (bus.sub) c_d = 1'b1;
`endif
    end else if (state_q == RUN) begin
      s_d[idx_q*CHUNK +: CHUNK] = sl_sum;
      c_d   = sl_c[CHUNK];
      idx_d = idx_q + 1'b1;
      if (last) begin
        idx_d  = '0;
        cout_d = sl_c[CHUNK];
        ovf_d  = sl_c[CHUNK] ^ sl_c[CHUNK-1];
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign bus.S    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench: random and directed ops on a 16/4 and a 32/8 instance,
// checked against plain-arithmetic expectations.
module tb_cla_seq_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_seq_if #(.WIDTH(16)) if16 ();
  cla_seq_if #(.WIDTH(32)) if32 ();

  cla_seq_adder #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16.slave)
  );

  cla_seq_adder #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if32.slave)
  );

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done16 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: A + B + cin (or A - B when subtract is built in), done
  // with wide integer arithmetic and the textbook signed-overflow rule.
  function automatic exp_t model(input int w, input logic [31:0] a,
                                 input logic [31:0] b, input logic ci,
                                 input logic sb);
    exp_t            e;
    longint unsigned m;
    longint unsigned bb;
    longint unsigned sum;
    logic            c0;
    m  = (64'd1 << w) - 1;
    bb = {32'd0, b};
    c0 = ci;
`ifdef CLA_SEQ_SUB_EN
    if (sb) begin
      bb = ~bb & m;
      c0 = 1'b1;
    end
`else
    if (sb) c0 = ci;
`endif
    sum   = {32'd0, a} + bb + {63'd0, c0};
    e.s   = 32'(sum & m);
    e.c   = sum[w];
    e.o   = (a[w-1] == bb[w-1]) && (e.s[w-1] != a[w-1]);
    e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] s, input logic c,
                              input logic o);
    exp_t e;
    e.s   = s;
    e.c   = c;
    e.o   = o;
    e.acc = 0;
    return e;
  endfunction

  task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sb, input exp_t e);
    int   n;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (if16.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (if16.busy) begin
      errors++;
      checks++;
      $display("FAIL idle_wait16: busy stuck at 1");
    end
    if16.start = 1'b1;
    if16.A     = a;
    if16.B     = b;
    if16.cin   = ci;
    if16.sub   = sb;
    x     = e;
    x.acc = cyc + 1;
    q16.push_back(x);
    @(negedge clk);
    if16.start = 1'b0;
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb);
    int   n;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (if32.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (if32.busy) begin
      errors++;
      checks++;
      $display("FAIL idle_wait32: busy stuck at 1");
    end
    if32.start = 1'b1;
    if32.A     = a;
    if32.B     = b;
    if32.cin   = ci;
    if32.sub   = sb;
    x     = model(32, a, b, ci, sb);
    x.acc = cyc + 1;
    q32.push_back(x);
    @(negedge clk);
    if32.start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q16.size() != 0 || q32.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q16.size() != 0 || q32.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d/%0d results never arrived",
               q16.size(), q32.size());
      q16.delete();
      q32.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if16.done) begin
      done16 = done16 + 1;
      if (q16.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL spurious_done16: S=%0h", if16.S);
      end else begin
        e = q16.pop_front();
        check("S16", {48'd0, if16.S}, {48'd0, e.s[15:0]});
        check("cout16", {63'd0, if16.cout}, {63'd0, e.c});
        check("ovf16", {63'd0, if16.ovf}, {63'd0, e.o});
        check("lat16", 64'(cyc - e.acc), 64'd4);
        check("busy_at_done16", {63'd0, if16.busy}, 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if32.done) begin
      if (q32.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL spurious_done32: S=%0h", if32.S);
      end else begin
        e = q32.pop_front();
        check("S32", {32'd0, if32.S}, {32'd0, e.s});
        check("cout32", {63'd0, if32.cout}, {63'd0, e.c});
        check("ovf32", {63'd0, if32.ovf}, {63'd0, e.o});
        check("lat32", 64'(cyc - e.acc), 64'd4);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   d0;
    exp_t e;
    logic [15:0] ra, rb;
    logic [31:0] wa, wb;
    logic rc, rs;
    if16.start = 1'b0; if16.A = '0; if16.B = '0;
    if16.cin = 1'b0; if16.sub = 1'b0;
    if32.start = 1'b0; if32.A = '0; if32.B = '0;
    if32.cin = 1'b0; if32.sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_S", {48'd0, if16.S}, 64'd0);
    check("rst_busy", {63'd0, if16.busy}, 64'd0);
    check("rst_done", {63'd0, if16.done}, 64'd0);
    check("rst_cout_ovf", {62'd0, if16.cout, if16.ovf}, 64'd0);
    rst_n = 1'b1;

    issue16(16'h1234, 16'h4321, 1'b0, 1'b0, mk(32'h5555, 1'b0, 1'b0));
    issue16(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(32'h0000, 1'b1, 1'b0));
    issue16(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(32'h8000, 1'b0, 1'b1));
`ifdef CLA_SEQ_SUB_EN
    issue16(16'h0005, 16'h0007, 1'b0, 1'b1, mk(32'hFFFE, 1'b0, 1'b0));
`else
    issue16(16'h0005, 16'h0007, 1'b0, 1'b1, mk(32'h000C, 1'b0, 1'b0));
`endif
    drain();

    d0 = done16;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if16.start = 1'b1;
      if16.A = ra; if16.B = rb; if16.cin = rc; if16.sub = 1'b0;
      if (!if16.busy) begin
        e     = model(16, {16'd0, ra}, {16'd0, rb}, rc, 1'b0);
        e.acc = cyc + 1;
        q16.push_back(e);
      end
    end
    @(negedge clk);
    if16.start = 1'b0;
    drain();
    check("t3_accepts", 64'(done16 - d0), 64'd3);

    issue16(16'hABCD, 16'h1111, 1'b1, 1'b0, mk(32'hBCDF, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t4_busy", {63'd0, if16.busy}, 64'd0);
    check("t4_done", {63'd0, if16.done}, 64'd0);
    check("t4_S", {48'd0, if16.S}, 64'd0);
    check("t4_cout_ovf", {62'd0, if16.cout, if16.ovf}, 64'd0);
    void'(q16.pop_back());
    rst_n = 1'b1;
    issue16(16'h0F0F, 16'h00F1, 1'b1, 1'b0, mk(32'h1001, 1'b0, 1'b0));
    drain();

    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = (i % 10 == 0) ? ~ra : 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      issue16(ra, rb, rc, rs, model(16, {16'd0, ra}, {16'd0, rb}, rc, rs));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain();

    for (int i = 0; i < 1000; i++) begin
      wa = $urandom;
      wb = (i % 16 == 0) ? ~wa : $urandom;
      rc = 1'($urandom);
      rs = 1'($urandom);
      issue32(wa, wb, rc, rs);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
